// File: rtl/if_pkg.sv
// Shared types and constants for the RV32I instruction-fetch front end.
package if_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        BOOT,
        RUN
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_buffer.sv
// In-order fetch buffer: slots are allocated at grant (PC), filled at response
// (instruction) and released at pop. Pointers carry one wrap bit.
module if_fetch_buffer
    import if_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int IW = $clog2(DEPTH),
    localparam int PW = IW + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            alloc_i,
    input  logic [XLEN-1:0] alloc_pc_i,
    input  logic            fill_i,
    input  logic [XLEN-1:0] fill_instr_i,
    input  logic            pop_i,
    output logic [PW-1:0]   occupancy_o,
    output logic [PW-1:0]   outstanding_o,
    output logic            head_valid_o,
    output logic [XLEN-1:0] head_pc_o,
    output logic [XLEN-1:0] head_instr_o
);

    fetch_entry_t mem [DEPTH];

    logic [PW-1:0] alloc_ptr;
    logic [PW-1:0] fill_ptr;
    logic [PW-1:0] rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
        end else if (flush_i) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
        end else begin
            if (alloc_i) alloc_ptr <= alloc_ptr + 1'b1;
            if (fill_i)  fill_ptr  <= fill_ptr + 1'b1;
            if (pop_i)   rd_ptr    <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which slots hold live data.
    always_ff @(posedge clk_i) begin
        if (alloc_i && !flush_i) mem[alloc_ptr[IW-1:0]].pc    <= alloc_pc_i;
        if (fill_i && !flush_i)  mem[fill_ptr[IW-1:0]].instr  <= fill_instr_i;
    end

    assign occupancy_o   = alloc_ptr - rd_ptr;
    assign outstanding_o = alloc_ptr - fill_ptr;
    assign head_valid_o  = (fill_ptr != rd_ptr);
    assign head_pc_o     = mem[rd_ptr[IW-1:0]].pc;
    assign head_instr_o  = mem[rd_ptr[IW-1:0]].instr;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: fetch PC, imem req/gnt/rvalid handshake,
// redirect flush with stale-response discard, and the in-order fetch buffer.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            stall_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int DW = PW + 1;
    localparam logic [PW-1:0] DEPTH_CNT = PW'(DEPTH);

    fetch_state_e    state, state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [DW-1:0]   discard;
    logic [PW-1:0]   occupancy;
    logic [PW-1:0]   outstanding;
    logic            head_valid;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] head_instr;
    logic            grant;
    logic            keep;
    logic            pop;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= BOOT;
        else       state <= state_nxt;
    end

    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    assign imem_req_o  = (state == RUN) && (occupancy < DEPTH_CNT) && !redirect_i;
    assign imem_addr_o = fetch_pc;
    assign grant       = imem_req_o && imem_gnt_i;
    assign keep        = imem_rvalid_i && !redirect_i && (discard == '0);
    assign pop         = head_valid && !stall_i && !redirect_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)           fetch_pc <= RESET_PC;
        else if (redirect_i) fetch_pc <= redirect_pc_i & ~XLEN'(3);
        else if (grant)      fetch_pc <= fetch_pc + XLEN'(4);
    end

    // Stale responses still owed from an earlier redirect stay in the count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            discard <= '0;
        else if (redirect_i)
            discard <= discard + DW'(outstanding) - DW'(imem_rvalid_i);
        else if (imem_rvalid_i && (discard != '0))
            discard <= discard - 1'b1;
    end

    if_fetch_buffer #(
        .DEPTH(DEPTH)
    ) u_buffer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (redirect_i),
        .alloc_i      (grant),
        .alloc_pc_i   (fetch_pc),
        .fill_i       (keep),
        .fill_instr_i (imem_rdata_i),
        .pop_i        (pop),
        .occupancy_o  (occupancy),
        .outstanding_o(outstanding),
        .head_valid_o (head_valid),
        .head_pc_o    (head_pc),
        .head_instr_o (head_instr)
    );

    assign instr_valid_o = head_valid;
    assign instr_o       = head_valid ? head_instr : NOP_INSTR;
    assign pc_o          = head_valid ? head_pc : '0;

endmodule
